// File: rtl/ysyx_22050612_regfile_sb_pkg.sv
// ysyx_22050612_regfile_sb_pkg: shared constants for the register file and its dump engine
// Contents: dump FSM state encodings, register-count helper and the x0 index constant.
package ysyx_22050612_regfile_sb_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int NREG = 2 ** ADDR_WIDTH_DEF;
    localparam int REG_ZERO = 0;
    function automatic int nreg(input int aw);
        return 2 ** aw;
    endfunction
endpackage

// File: rtl/ysyx_22050612_rf_dump_fsm.sv
// ysyx_22050612_rf_dump_fsm: handshaked engine streaming every register index once
// Ports: clk/rst (async active-high); dump_req starts a dump from idle;
// dump_valid/dump_ready handshake; dump_idx is the beat index, also used as the
// array read index; rd_data is the array value at dump_idx, forwarded as dump_data;
// dump_busy is high outside idle; dump_done pulses for one cycle after the last beat.
module ysyx_22050612_rf_dump_fsm
    import ysyx_22050612_regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dump_req,
    input  logic                  dump_ready,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_idx,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);
    logic [1:0] state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    wire last = idx_q == {ADDR_WIDTH{1'b1}};
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        case (state_q)
            S_IDLE: if (dump_req) begin
                state_d = S_SEND;
                idx_d = '0;
            end
            S_SEND: if (dump_ready) begin
                state_d = last ? S_DONE : S_SEND;
                idx_d = last ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                idx_d = '0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
        end
    assign dump_valid = state_q == S_SEND;
    assign dump_busy = state_q != S_IDLE;
    assign dump_done = state_q == S_DONE;
    assign dump_idx = idx_q;
    assign dump_data = rd_data;
endmodule

// File: rtl/ysyx_22050612_regfile_sb.sv
// ysyx_22050612_regfile_sb: multi-read register file with x0, write bypass, busy scoreboard and dump
// Ports: clk/rst (async active-high); wen/waddr/wdata writeback port;
// raddr/rdata/rbusy packed NREAD read ports (port i at slice i); issue_en/issue_rd
// mark a destination busy; dump_* is the handshaked full-register dump interface.
module ysyx_22050612_regfile_sb
    import ysyx_22050612_regfile_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NREAD = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        issue_en,
    input  logic [ADDR_WIDTH-1:0]       issue_rd,
    input  logic                        dump_req,
    output logic                        dump_valid,
    input  logic                        dump_ready,
    output logic [ADDR_WIDTH-1:0]       dump_idx,
    output logic [DATA_WIDTH-1:0]       dump_data,
    output logic                        dump_busy,
    output logic                        dump_done
);
    localparam int NR = nreg(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
    logic [DATA_WIDTH-1:0] rf_q [NR];
    logic [NR-1:0] busy_q, busy_d;
    wire wr = wen && waddr != ZERO;
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NR; i++) rf_q[i] <= '0;
        else if (wr) rf_q[waddr] <= wdata;
    // A new issue in the same cycle as the old producer's writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr) busy_d[waddr] = 1'b0;
        if (issue_en && issue_rd != ZERO) busy_d[issue_rd] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic hit;
        assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = wr && waddr == ra;
        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = hit ? wdata : (ra == ZERO ? '0 : rf_q[ra]);
        assign rbusy[g] = busy_q[ra] && !hit && ra != ZERO;
    end
    logic [ADDR_WIDTH-1:0] didx;
    logic [DATA_WIDTH-1:0] drd;
    // Dump sees the committed array only; same-cycle writes are not bypassed.
    assign drd = didx == ZERO ? '0 : rf_q[didx];
    assign dump_idx = didx;
    ysyx_22050612_rf_dump_fsm #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dump (
        .clk(clk),
        .rst(rst),
        .dump_req(dump_req),
        .dump_ready(dump_ready),
        .rd_data(drd),
        .dump_valid(dump_valid),
        .dump_idx(didx),
        .dump_data(dump_data),
        .dump_busy(dump_busy),
        .dump_done(dump_done)
    );
endmodule

// File: tb/tb_ysyx_22050612_regfile_sb.sv
// tb_ysyx_22050612_regfile_sb: scenario bench for the register file, scoreboard and dump engine
module tb_ysyx_22050612_regfile_sb;
    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] data;
    } beat_t;
    logic clk = 0, rst = 0, wen = 0, issue_en = 0, dump_req = 0, dump_ready = 0;
    logic [4:0] waddr = 0, issue_rd = 0;
    logic [63:0] wdata = 0;
    logic [9:0] raddr = 0;
    logic [127:0] rdata;
    logic [1:0] rbusy;
    logic dump_valid, dump_busy, dump_done;
    logic [4:0] dump_idx;
    logic [63:0] dump_data;
    int total = 0, bad = 0;
    beat_t q[$];
    ysyx_22050612_regfile_sb dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            total++;
            if (rdata !== 128'd0 || rbusy !== 2'b00 || dump_busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_read idx=%0d rdata=%h rbusy=%b dump_busy=%b want 0/00/0", i, rdata, rbusy, dump_busy);
            end
        end
    endtask
    task automatic test_x0;
        wen = 1; waddr = 0; wdata = 64'hDEAD; raddr = 10'd0;
        #1;
        total++;
        if (rdata !== 128'd0) begin bad++; $display("FAIL x0_bypass got=%h want 0", rdata); end
        tick();
        wen = 0;
        #1;
        total++;
        if (rdata !== 128'd0) begin bad++; $display("FAIL x0_array got=%h want 0", rdata); end
    endtask
    task automatic test_bypass;
        wen = 1; waddr = 5; wdata = 64'h1234; raddr = {5'd5, 5'd5};
        #1;
        total++;
        if (rdata !== {64'h1234, 64'h1234}) begin bad++; $display("FAIL bypass got=%h want both 1234", rdata); end
        tick();
        wen = 0;
        #1;
        total++;
        if (rdata[63:0] !== 64'h1234) begin bad++; $display("FAIL array_read got=%h want 1234", rdata[63:0]); end
        raddr = {5'd5, 5'd0};
        #1;
        total++;
        if (rdata !== {64'h1234, 64'h0}) begin bad++; $display("FAIL port_pack got=%h want 1234/0", rdata); end
    endtask
    task automatic test_scoreboard;
        raddr = {5'd7, 5'd0};
        issue_en = 1; issue_rd = 7;
        #1;
        total++;
        if (rbusy !== 2'b00) begin bad++; $display("FAIL issue_same_cycle rbusy=%b want 00", rbusy); end
        tick();
        issue_en = 0;
        #1;
        total++;
        if (rbusy !== 2'b10) begin bad++; $display("FAIL busy_set rbusy=%b want 10", rbusy); end
        wen = 1; waddr = 7; wdata = 64'h77;
        #1;
        total++;
        if (rbusy !== 2'b00) begin bad++; $display("FAIL busy_wb_comb rbusy=%b want 00", rbusy); end
        tick();
        wen = 0;
        #1;
        total++;
        if (rbusy !== 2'b00) begin bad++; $display("FAIL busy_cleared rbusy=%b want 00", rbusy); end
        issue_en = 1; issue_rd = 7;
        tick();
        wen = 1; waddr = 7; wdata = 64'h78;
        tick();
        issue_en = 0; wen = 0;
        #1;
        total++;
        if (rbusy !== 2'b10) begin bad++; $display("FAIL set_wins rbusy=%b want 10", rbusy); end
        issue_en = 1; issue_rd = 0;
        tick();
        issue_en = 0; raddr = {5'd0, 5'd0};
        #1;
        total++;
        if (rbusy !== 2'b00) begin bad++; $display("FAIL x0_busy rbusy=%b want 00", rbusy); end
        wen = 1; waddr = 7; wdata = 64'h79;
        tick();
        wen = 0;
    endtask
    task automatic preload;
        for (int i = 1; i < 32; i++) begin
            wen = 1; waddr = 5'(i); wdata = 64'(i * 3);
            tick();
        end
        wen = 0;
    endtask
    task automatic run_dump(input logic [3:0] pat, input bit strict);
        int exp_idx = 0;
        for (int i = 0; i < 32; i++) q.push_back('{idx: 5'(i), data: 64'(i * 3)});
        dump_req = 1; dump_ready = pat[0];
        tick();
        dump_req = 0;
        for (int c = 0; c < 200 && q.size() > 0; c++) begin
            dump_ready = pat[c % 4];
            dump_req = (c == 3);
            #1;
            if (dump_valid) begin
                total++;
                if (dump_idx !== q[0].idx || dump_data !== q[0].data) begin
                    bad++;
                    $display("FAIL dump_beat idx=%0d data=%0d want idx=%0d data=%0d", dump_idx, dump_data, q[0].idx, q[0].data);
                end
                if (dump_ready) begin void'(q.pop_front()); exp_idx++; end
            end else if (strict) begin
                total++; bad++;
                $display("FAIL dump_gap cycle=%0d valid=0 want 1", c);
            end
            @(posedge clk);
            #1;
        end
        dump_req = 0;
        total++;
        if (q.size() != 0 || exp_idx != 32) begin
            bad++;
            $display("FAIL dump_count left=%0d beats=%0d want 0/32", q.size(), exp_idx);
            q.delete();
        end
        #1;
        total++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1 || dump_idx !== 5'd0) begin
            bad++;
            $display("FAIL dump_done_pulse done=%b valid=%b busy=%b idx=%0d want 1/0/1/0", dump_done, dump_valid, dump_busy, dump_idx);
        end
        tick();
        #1;
        total++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL dump_idle done=%b busy=%b want 0/0", dump_done, dump_busy);
        end
    endtask
    task automatic test_dump_full;
        preload();
        run_dump(4'b1111, 1'b1);
    endtask
    task automatic test_dump_stall;
        run_dump(4'b1001, 1'b0);
    endtask
    task automatic test_reset_mid_dump;
        int c = 0;
        dump_req = 1; dump_ready = 1;
        tick();
        dump_req = 0;
        while (dump_idx != 5'd10 && c < 50) begin tick(); c++; end
        total++;
        if (c >= 50) begin bad++; $display("FAIL mid_dump_reach idx=%0d want 10", dump_idx); end
        #1;
        rst = 1;
        #1;
        total++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_idx !== 5'd0) begin
            bad++;
            $display("FAIL async_abort valid=%b busy=%b idx=%0d want 0/0/0", dump_valid, dump_busy, dump_idx);
        end
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            raddr = {5'(i + 20), 5'(i + 3)};
            #1;
            total++;
            if (dump_done !== 1'b0 || rdata !== 128'd0 || dump_busy !== 1'b0) begin
                bad++;
                $display("FAIL post_abort done=%b rdata=%h busy=%b want 0/0/0", dump_done, rdata, dump_busy);
            end
            tick();
        end
    endtask
    initial begin
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_dump_full();
        test_dump_stall();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_regfile_sb.md
Name: ysyx_22050612_regfile_sb

Overview:
Parametrised integer register file for the pipelined NPC core. Generalises the single-write, two-read array to NREAD combinational read ports and adds four features:
- x0 hardwired to zero
- same-cycle write-to-read bypass
- per-register busy scoreboard for issue-stage hazard checks
- handshaked dump engine that streams every register out for difftest/trace

Sits between decode/issue (reads, busy checks, issue marks) and writeback (write port).

Parameters:
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 64, register width
NREAD, 2, number of read ports (>=1)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
wen  in  1  writeback write enable
waddr  in  ADDR_WIDTH  writeback register index
wdata  in  DATA_WIDTH  writeback data
raddr  in  NREAD*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NREAD*DATA_WIDTH  packed read data, same packing
rbusy  out  NREAD  per-port: addressed register has an outstanding producer
issue_en  in  1  mark a destination register busy
issue_rd  in  ADDR_WIDTH  destination register being issued
dump_req  in  1  start a full-register dump (accepted only when idle)
dump_valid  out  1  dump beat valid
dump_ready  in  1  consumer accepts dump beat
dump_idx  out  ADDR_WIDTH  index of current dump beat
dump_data  out  DATA_WIDTH  value of register dump_idx
dump_busy  out  1  dump engine not idle
dump_done  out  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset (async, rst=1): all registers 0, all busy bits 0, FSM=IDLE, dump_valid=0, dump_done=0, dump_busy=0, dump_idx=0. Reset mid-dump aborts the dump with no done pulse.
- x0: writes to index 0 ignored; reads of 0 return 0; busy[0] never set; rbusy for index 0 is always 0.
- Write: on posedge with wen=1 and waddr!=0, rf[waddr] <= wdata.
- Read: combinational, zero latency.
  - Port i: if wen && waddr==raddr_i && waddr!=0, rdata_i = wdata (bypass); else rf[raddr_i].
  - Multiple ports may read the same index.
- Scoreboard, posedge:
  - wen && waddr!=0 clears busy[waddr].
  - issue_en && issue_rd!=0 sets busy[issue_rd].
  - Same index in one cycle: set wins (new producer supersedes).
  - rbusy_i = busy[raddr_i] && !(wen && waddr==raddr_i), with the x0 rule above.
  - issue_en in the same cycle does not affect rbusy (registered effect only).
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: dump_req=1 -> SEND, dump_idx<=0. dump_req in SEND/DONE is ignored (no queueing).
  - SEND: dump_valid=1; dump_data = rf[dump_idx], array value without bypass (index 0 gives 0).
    - dump_valid && dump_ready: if dump_idx==2**ADDR_WIDTH-1 -> DONE, else dump_idx+1.
    - Without ready, dump_idx holds. dump_data may change if writeback hits that index; the consumer samples on handshake.
  - DONE: dump_done=1 for exactly one cycle, then IDLE. dump_idx returns to 0.
  - dump_busy=1 in SEND and DONE.
  - Writes and scoreboard continue normally during a dump.
- Full dump, ready always high: 2**ADDR_WIDTH beats in consecutive cycles, then the done cycle.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, SEND=2'd1, DONE=2'd2
  - register-count localparam NREG = 2**ADDR_WIDTH
  - index constant REG_ZERO = 0
- Natural sub-module: ysyx_22050612_rf_dump_fsm, the dump engine (state, index counter, handshake). It reads the array through an index/data pair.
- Array, bypass and scoreboard stay in the top module.

Test Plan:
- Reset then read all indices on both ports -> rdata=0, rbusy=0, dump_busy=0. Write x0 with 0xDEAD -> reads of x0 still 0.
- Write x5=0x1234 with raddr0=5 in the same cycle -> rdata0=0x1234 that cycle (bypass); next cycle with wen=0 -> 0x1234 from the array.
- issue_en rd=7 -> next cycle rbusy=1 for raddr=7. Cycle with wen waddr=7 -> rbusy=0 combinationally, busy cleared after the edge. Simultaneous issue rd=7 and wen waddr=7 -> busy stays 1.
- Preload xi=i*3, dump_req with dump_ready=1 -> 32 beats, dump_idx 0..31 in consecutive cycles, dump_data 0,3,...,93, then dump_done=1 for one cycle.
- Dump with dump_ready toggling 1,0,0,1 -> dump_idx advances only on handshake cycles. dump_req during SEND -> no restart. Total beats remain 32.
- Assert rst at beat 10 of a dump -> dump_valid=0 and dump_busy=0 immediately (async). No dump_done. Registers read back as 0.
